// File: rtl/id_stage.sv
// RV32I decode stage: register file with WB bypass, load-use stall and a
// redirect FSM that squashes the entries fetched behind a control-flow instruction.
package core_pkg;
  typedef enum logic {NEXTPC = 1'b0, ALU_RESULT = 1'b1} pc_mux_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        ctrl_flow;
  } id_ex_t;
endpackage

module id_stage
  import core_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid_ip,
  input  logic [31:0] instr_data_ip,
  input  logic [31:0] instr_pc_addr_ip,
  input  logic        alu_result_valid_ip,
  input  logic        wb_we_ip,
  input  logic [4:0]  wb_rd_ip,
  input  logic [31:0] wb_data_ip,
  output logic        stall_op,
  output pc_mux_t     pc_mux_op,
  output logic        ex_valid_op,
  output logic [31:0] ex_pc_op,
  output logic [31:0] ex_rs1_data_op,
  output logic [31:0] ex_rs2_data_op,
  output logic [31:0] ex_imm_op,
  output logic [4:0]  ex_rd_op,
  output logic [6:0]  ex_opcode_op,
  output logic [2:0]  ex_funct3_op,
  output logic [6:0]  ex_funct7_op,
  output logic        ex_mem_read_op,
  output logic        ex_mem_write_op,
  output logic        ex_reg_write_op,
  output logic        ex_ctrl_flow_op,
  output logic        illegal_instr_op
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {RUN, BR_WAIT, BR_FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] rf [32];
  id_ex_t      id_ex, id_ex_nxt;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0] rs1_data, rs2_data;
  logic        legal, use_rs1, use_rs2, mem_read, mem_write, reg_write, ctrl_flow;
  logic        hazard, squash, issue, illegal;

  assign instr  = instr_data_ip;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    legal     = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    ctrl_flow = 1'b0;
    imm       = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin reg_write = 1'b1; imm = imm_u; end
      OP_JAL:    begin reg_write = 1'b1; ctrl_flow = 1'b1; imm = imm_j; end
      OP_JALR:   begin reg_write = 1'b1; ctrl_flow = 1'b1; use_rs1 = 1'b1; imm = imm_i; end
      OP_BRANCH: begin ctrl_flow = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; end
      OP_LOAD:   begin reg_write = 1'b1; mem_read = 1'b1; use_rs1 = 1'b1; imm = imm_i; end
      OP_STORE:  begin mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s; end
      OP_IMM:    begin reg_write = 1'b1; use_rs1 = 1'b1; imm = imm_i; end
      OP_OP:     begin reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  // Write-through: a WB write this cycle is visible to the decode reading it.
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_we_ip && wb_rd_ip == rs1) ? wb_data_ip : rf[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_we_ip && wb_rd_ip == rs2) ? wb_data_ip : rf[rs2];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_ip && wb_rd_ip != 5'd0) begin
      rf[wb_rd_ip] <= wb_data_ip;
    end
  end

  assign hazard = instr_valid_ip && id_ex.valid && id_ex.mem_read && id_ex.rd != 5'd0 &&
                  ((use_rs1 && rs1 == id_ex.rd) || (use_rs2 && rs2 == id_ex.rd));
  assign issue   = (state == RUN) && instr_valid_ip && legal && !hazard;
  assign illegal = (state == RUN) && instr_valid_ip && !legal;
  assign stall_op = !reset && (state == RUN) && hazard;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (issue && ctrl_flow) state_nxt = BR_WAIT;
      BR_WAIT:  if (alu_result_valid_ip) state_nxt = BR_FLUSH;
      BR_FLUSH: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_mux_op = NEXTPC;
    squash    = 1'b0;
    case (state)
      BR_WAIT:  begin pc_mux_op = ALU_RESULT; squash = 1'b1; end
      BR_FLUSH: squash = 1'b1;
      default:  ;
    endcase
    if (reset) pc_mux_op = NEXTPC;
  end

  always_comb begin
    id_ex_nxt = '0;
    if (issue && !squash) begin
      id_ex_nxt.valid     = 1'b1;
      id_ex_nxt.pc        = instr_pc_addr_ip;
      id_ex_nxt.rs1_data  = rs1_data;
      id_ex_nxt.rs2_data  = rs2_data;
      id_ex_nxt.imm       = imm;
      id_ex_nxt.rd        = reg_write ? instr[11:7] : 5'd0;
      id_ex_nxt.opcode    = opcode;
      id_ex_nxt.funct3    = instr[14:12];
      id_ex_nxt.funct7    = instr[31:25];
      id_ex_nxt.mem_read  = mem_read;
      id_ex_nxt.mem_write = mem_write;
      id_ex_nxt.reg_write = reg_write;
      id_ex_nxt.ctrl_flow = ctrl_flow;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      id_ex            <= '0;
      illegal_instr_op <= 1'b0;
    end else begin
      id_ex            <= id_ex_nxt;
      illegal_instr_op <= illegal;
    end
  end

  assign ex_valid_op     = id_ex.valid;
  assign ex_pc_op        = id_ex.pc;
  assign ex_rs1_data_op  = id_ex.rs1_data;
  assign ex_rs2_data_op  = id_ex.rs2_data;
  assign ex_imm_op       = id_ex.imm;
  assign ex_rd_op        = id_ex.rd;
  assign ex_opcode_op    = id_ex.opcode;
  assign ex_funct3_op    = id_ex.funct3;
  assign ex_funct7_op    = id_ex.funct7;
  assign ex_mem_read_op  = id_ex.mem_read;
  assign ex_mem_write_op = id_ex.mem_write;
  assign ex_reg_write_op = id_ex.reg_write;
  assign ex_ctrl_flow_op = id_ex.ctrl_flow;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a cycle-level reference model pushes expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_id_stage;
  import core_pkg::*;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid_ip = 1'b0;
  logic [31:0] instr_data_ip = '0, instr_pc_addr_ip = '0;
  logic        alu_result_valid_ip = 1'b0, wb_we_ip = 1'b0;
  logic [4:0]  wb_rd_ip = '0;
  logic [31:0] wb_data_ip = '0;
  logic        stall_op, ex_valid_op, ex_mem_read_op, ex_mem_write_op, ex_reg_write_op;
  logic        ex_ctrl_flow_op, illegal_instr_op;
  pc_mux_t     pc_mux_op;
  logic [31:0] ex_pc_op, ex_rs1_data_op, ex_rs2_data_op, ex_imm_op;
  logic [4:0]  ex_rd_op;
  logic [6:0]  ex_opcode_op, ex_funct7_op;
  logic [2:0]  ex_funct3_op;

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset), .instr_valid_ip(instr_valid_ip), .instr_data_ip(instr_data_ip),
    .instr_pc_addr_ip(instr_pc_addr_ip), .alu_result_valid_ip(alu_result_valid_ip),
    .wb_we_ip(wb_we_ip), .wb_rd_ip(wb_rd_ip), .wb_data_ip(wb_data_ip),
    .stall_op(stall_op), .pc_mux_op(pc_mux_op), .ex_valid_op(ex_valid_op), .ex_pc_op(ex_pc_op),
    .ex_rs1_data_op(ex_rs1_data_op), .ex_rs2_data_op(ex_rs2_data_op), .ex_imm_op(ex_imm_op),
    .ex_rd_op(ex_rd_op), .ex_opcode_op(ex_opcode_op), .ex_funct3_op(ex_funct3_op),
    .ex_funct7_op(ex_funct7_op), .ex_mem_read_op(ex_mem_read_op), .ex_mem_write_op(ex_mem_write_op),
    .ex_reg_write_op(ex_reg_write_op), .ex_ctrl_flow_op(ex_ctrl_flow_op),
    .illegal_instr_op(illegal_instr_op)
  );

  typedef struct { int tag; logic stall; pc_mux_t pcm; } comb_exp_t;
  typedef struct {
    int tag; logic valid; logic [31:0] pc, rs1, rs2, imm; logic [4:0] rd;
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic mr, mw, rw, cf, ill;
  } ex_exp_t;

  comb_exp_t   comb_q[$];
  ex_exp_t     ex_q[$];
  int          edges = 0, checks = 0, errors = 0;
  logic [31:0] m_rf [32];
  bit          m_wait, m_flush, m_stall;
  ex_exp_t     m_ex;

  always @(posedge clock) edges <= edges + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edges, act, exp);
    end
  endtask

  always @(negedge clock) begin
    comb_exp_t c;
    ex_exp_t   e;
    if (comb_q.size() > 0 && comb_q[0].tag == edges) begin
      c = comb_q.pop_front();
      chk("stall", 32'(stall_op), 32'(c.stall));
      chk("pc_mux", 32'(pc_mux_op), 32'(c.pcm));
    end
    if (ex_q.size() > 0 && ex_q[0].tag == edges) begin
      e = ex_q.pop_front();
      chk("ex_valid", 32'(ex_valid_op), 32'(e.valid));
      chk("ex_pc", ex_pc_op, e.pc);
      chk("ex_rs1", ex_rs1_data_op, e.rs1);
      chk("ex_rs2", ex_rs2_data_op, e.rs2);
      chk("ex_imm", ex_imm_op, e.imm);
      chk("ex_rd", 32'(ex_rd_op), 32'(e.rd));
      chk("ex_opcode", 32'(ex_opcode_op), 32'(e.op));
      chk("ex_funct3", 32'(ex_funct3_op), 32'(e.f3));
      chk("ex_funct7", 32'(ex_funct7_op), 32'(e.f7));
      chk("ex_flags", {28'd0, ex_mem_read_op, ex_mem_write_op, ex_reg_write_op, ex_ctrl_flow_op},
          {28'd0, e.mr, e.mw, e.rw, e.cf});
      chk("illegal", 32'(illegal_instr_op), 32'(e.ill));
    end
  end

  // Immediates built from weighted bit fields, sign bit counted as a negative weight.
  function automatic logic [31:0] imm_of(logic [31:0] w);
    int s = w[31] ? 1 : 0;
    case (w[6:0])
      LUI, AUIPC:   return w & 32'hFFFF_F000;
      JAL:          return 32'(-s * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      BR:           return 32'(-s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      ST:           return 32'(-s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
      JALR, LD, OPI: return 32'(-s * 2048 + int'(w[30:20]));
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd_rf(logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we_ip && wb_rd_ip == r) return wb_data_ip;
    return m_rf[r];
  endfunction

  task automatic model_step();
    comb_exp_t  c;
    ex_exp_t    n;
    logic [6:0] op;
    logic [4:0] r1, r2;
    bit         legal, u1, u2, hz, sq;
    c = '{tag: edges, stall: 1'b0, pcm: NEXTPC};
    n = '{default: 0};
    n.tag = edges + 1;
    if (reset) begin
      m_wait = 0; m_flush = 0;
      foreach (m_rf[i]) m_rf[i] = '0;
    end else begin
      sq = m_wait || m_flush;
      op = instr_data_ip[6:0];
      r1 = instr_data_ip[19:15];
      r2 = instr_data_ip[24:20];
      legal = op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};
      u1 = op inside {JALR, BR, LD, ST, OPI, OPR};
      u2 = op inside {BR, ST, OPR};
      hz = !sq && instr_valid_ip && m_ex.valid && m_ex.mr && m_ex.rd != 0 &&
           ((u1 && r1 == m_ex.rd) || (u2 && r2 == m_ex.rd));
      c.stall = hz;
      c.pcm   = m_wait ? ALU_RESULT : NEXTPC;
      if (!sq && instr_valid_ip && legal && !hz) begin
        n.valid = 1; n.pc = instr_pc_addr_ip;
        n.rs1 = rd_rf(r1); n.rs2 = rd_rf(r2); n.imm = imm_of(instr_data_ip);
        n.op = op; n.f3 = instr_data_ip[14:12]; n.f7 = instr_data_ip[31:25];
        n.mr = (op == LD); n.mw = (op == ST);
        n.rw = op inside {LUI, AUIPC, JAL, JALR, LD, OPI, OPR};
        n.rd = n.rw ? instr_data_ip[11:7] : 5'd0;
        n.cf = op inside {JAL, JALR, BR};
      end
      n.ill = !sq && instr_valid_ip && !legal;
      if (m_wait) begin
        if (alu_result_valid_ip) begin m_wait = 0; m_flush = 1; end
      end else if (m_flush) m_flush = 0;
      else if (n.valid && n.cf) m_wait = 1;
      if (wb_we_ip && wb_rd_ip != 0) m_rf[wb_rd_ip] = wb_data_ip;
    end
    m_stall = c.stall;
    m_ex = n;
    comb_q.push_back(c);
    ex_q.push_back(n);
  endtask

  task automatic step(bit rst, bit v, logic [31:0] ins, logic [31:0] pc, bit alu,
                      bit we, logic [4:0] wrd, logic [31:0] wd);
    reset = rst; instr_valid_ip = v; instr_data_ip = ins; instr_pc_addr_ip = pc;
    alu_result_valid_ip = alu; wb_we_ip = we; wb_rd_ip = wrd; wb_data_ip = wd;
    model_step();
    @(posedge clock); #1;
  endtask

  logic [6:0] ops[10] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, 7'h7F};

  initial begin
    logic [31:0] ins, pc;
    @(posedge clock); #1;
    // reset, write x5, reset twice, then read x5
    step(1, 0, NOP, 0, 0, 0, 0, 0);
    step(0, 1, NOP, 32'h0, 0, 1, 5'd5, 32'h55);
    step(1, 0, NOP, 0, 0, 0, 0, 0);
    step(1, 0, NOP, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0002_8093, 32'h4, 0, 0, 0, 0);           // ADDI x1,x5,0
    step(0, 1, 32'hFFD0_8113, 32'h8, 0, 1, 5'd1, 32'h10);   // ADDI x2,x1,-3 with bypass
    // load-use: LW x3,0(x4); ADD x5,x3,x6 held one extra cycle
    step(0, 1, 32'h0002_2183, 32'hC, 0, 0, 0, 0);
    step(0, 1, 32'h0061_82B3, 32'h10, 0, 0, 0, 0);
    step(0, 1, 32'h0061_82B3, 32'h10, 0, 0, 0, 0);
    step(0, 1, 32'h0002_2183, 32'h14, 0, 0, 0, 0);
    step(0, 1, 32'h0000_02B3, 32'h18, 0, 0, 0, 0);          // ADD x5,x0,x0
    // branch with the ALU result three cycles late
    step(0, 1, 32'h0020_8463, 32'h20, 0, 0, 0, 0);          // BEQ x1,x2,+8
    for (int i = 0; i < 3; i++) step(0, 1, NOP, 32'h24 + 4 * i, 0, 0, 0, 0);
    step(0, 1, NOP, 32'h30, 1, 0, 0, 0);
    step(0, 1, NOP, 32'h28, 1, 0, 0, 0);
    step(0, 1, NOP, 32'h2C, 1, 0, 0, 0);
    // x0 write ignored, then illegal opcode
    step(0, 1, 32'h0000_02B3, 32'h30, 0, 1, 5'd0, 32'hFFFF);
    step(0, 1, 32'h0000_007F, 32'h34, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0113, 32'h38, 0, 0, 0, 0);          // ADDI x2,x0,0
    // reset while waiting on a redirect
    step(0, 1, 32'h0080_006F, 32'h40, 0, 0, 0, 0);          // JAL x0,+8
    step(0, 1, NOP, 32'h44, 0, 0, 0, 0);
    step(1, 1, NOP, 32'h48, 0, 0, 0, 0);
    step(0, 1, NOP, 32'h48, 1, 0, 0, 0);
    step(0, 1, NOP, 32'h4C, 0, 0, 0, 0);
    // randomized traffic; a stalled entry is re-presented like fetch would
    ins = NOP; pc = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      if (!m_stall) begin
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        pc = pc + 4;
        step($urandom_range(0, 99) < 2, m_stall || $urandom_range(0, 9) != 0, ins, pc,
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 7)), $urandom);
      end else begin
        step(0, 1, ins, pc, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 7)), $urandom);
      end
    end
    repeat (2) @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(comb_q.size() + ex_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the 5-stage RISCV core. Sits directly downstream of the instruction fetch stage and consumes its IF/ID buffer. Decodes RV32I instructions, reads the 32x32 register file (written back from WB), detects load-use hazards, and drives the fetch stage's `stall` and `pc_mux` controls. Produces the registered ID/EX pipeline buffer.

## Interface
- No parameters. Register file depth and width are fixed at 32 x 32.
- `clock` input 1: single core clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_valid_ip` input 1: IF/ID entry is valid.
- `instr_data_ip` input 32: IF/ID instruction word.
- `instr_pc_addr_ip` input 32: IF/ID instruction PC.
- `alu_result_valid_ip` input 1: EX has produced the control-flow target this cycle.
- `wb_we_ip` input 1: register write enable from WB.
- `wb_rd_ip` input 5: register index written from WB.
- `wb_data_ip` input 32: data written from WB.
- `stall_op` output 1: to fetch `stall_ip`. Combinational.
- `pc_mux_op` output pc_mux: to fetch `pc_mux_ip` (NEXTPC/ALU_RESULT from CORE_PKG). Combinational.
- `ex_valid_op` output 1: ID/EX entry valid.
- `ex_pc_op` output 32: ID/EX instruction PC.
- `ex_rs1_data_op`, `ex_rs2_data_op` output 32: ID/EX source operands.
- `ex_imm_op` output 32: ID/EX sign-extended immediate.
- `ex_rd_op` output 5: ID/EX destination register index.
- `ex_opcode_op` output 7: ID/EX opcode.
- `ex_funct3_op` output 3: ID/EX funct3.
- `ex_funct7_op` output 7: ID/EX funct7.
- `ex_mem_read_op`, `ex_mem_write_op`, `ex_reg_write_op`, `ex_ctrl_flow_op` output 1: ID/EX control flags.
- `illegal_instr_op` output 1: registered one-cycle pulse for an unsupported opcode.

## Operation
- **Supported opcodes:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode on a valid entry gives a bubble plus `illegal_instr_op`=1 for one cycle.
- **Immediates:** I, S, B, U and J formats, sign-extended to 32 bits. R-type gives imm=0.
- **Register file:**
  - x0 reads 0 always; writes to x0 are ignored.
  - Write occurs at the clock edge when `wb_we_ip`=1.
  - Same-cycle read of `wb_rd_ip` (nonzero) returns `wb_data_ip` (write-through bypass).
- **rs1/rs2 usage:**
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
- **Load-use hazard:** raised when all of the following hold:
  - `ex_valid_op`=1, `ex_mem_read_op`=1 and `ex_rd_op`!=0;
  - `ex_rd_op` matches a used rs field of a valid incoming instruction.
- **Hazard response:**
  - `stall_op`=1 and a bubble is written to ID/EX.
  - The IF/ID entry is held by fetch and re-decoded next cycle.
- **Control-flow FSM:** states RUN, BR_WAIT, BR_FLUSH.
- **RUN:**
  - `pc_mux_op`=NEXTPC.
  - A valid, non-stalled JAL/JALR/BRANCH issues to ID/EX with `ex_ctrl_flow_op`=1, then moves to BR_WAIT.
  - Hazard has priority: a stalled branch does not issue and the state stays RUN.
- **BR_WAIT:**
  - `pc_mux_op`=ALU_RESULT and `stall_op`=0.
  - Every incoming entry is squashed, so ID/EX gets a bubble.
  - When `alu_result_valid_ip`=1, moves to BR_FLUSH.
- **BR_FLUSH:**
  - `pc_mux_op`=NEXTPC.
  - Squashes the one stale entry latched on the redirect edge, then moves to RUN.
- **Bubble:** every ID/EX field is set to 0, including `ex_valid_op`.

## Timing
- **Reset:** on a reset edge the following all become 0 and the FSM goes to RUN:
  - all `ex_*` outputs;
  - `illegal_instr_op`;
  - all 32 register-file entries.
- **Combinational outputs during reset:** `stall_op`=0 and `pc_mux_op`=NEXTPC.
- **Reset priority:** reset overrides every other condition, including mid-BR_WAIT; no redirect is pending afterwards.
- **Latency:** one cycle from IF/ID to ID/EX.
  - The instruction is registered at the edge after it is presented, unless stalled or squashed.
- **Load-use stall:** exactly one cycle per load. Next cycle the ID/EX entry is the bubble, so no hazard remains.
- **Branch cost:** minimum 2 squashed cycles after a branch issues, when `alu_result_valid_ip` arrives the next cycle.
  - Each additional cycle in BR_WAIT adds one squash.
- **Ignored inputs:**
  - `alu_result_valid_ip` is ignored in RUN and BR_FLUSH.
  - `instr_valid_ip`=0 in RUN writes a bubble and changes no state.
- **WB vs hazard:** a simultaneous WB write and load-use hazard on the same register still stalls, because the hazard check uses the ID/EX entry only.

## Test plan
- **Reset:** hold reset 2 cycles with x5 previously written.
  - Required: all `ex_*`=0, `stall_op`=0, `pc_mux_op`=NEXTPC, and reading x5 returns 0.
- **ALU decode plus bypass:** WB writes x1=0x10 while the ADDI x2,x1,-3 (0xFFD08113) sits in IF/ID at PC 0x8.
  - Required, next edge: `ex_rs1_data_op`=0x10, `ex_imm_op`=0xFFFFFFFD, `ex_rd_op`=2, `ex_reg_write_op`=1, `ex_pc_op`=0x8.
- **Load-use:** LW x3,0(x4), then ADD x5,x3,x6.
  - Required: `stall_op`=1 for exactly one cycle, one bubble, then ADD issues.
  - LW followed by ADD x5,x0,x0 gives no stall.
- **Branch:** BEQ issued at PC 0x20, `alu_result_valid_ip` held low 3 cycles then high.
  - Required: `pc_mux_op`=ALU_RESULT for 4 cycles, then 5 squashed entries in total, then RUN.
- **x0 and illegal:** WB writes x0=0xFFFF, then an instruction with opcode 0x7F.
  - Required: x0 still reads 0, one bubble, and `illegal_instr_op` pulses for 1 cycle.
- **Reset mid-branch:** assert reset while in BR_WAIT.
  - Required: next cycle the FSM is in RUN with `pc_mux_op`=NEXTPC and `ex_valid_op`=0.
